// File: rtl/acl_sched_if.sv
// rtl/acl_sched_if.sv - byte-engine handshake and chip-select bundle for acl_sched
interface acl_sched_if;
    logic       spi_req;
    logic [7:0] spi_tx;
    logic       spi_ack;
    logic [7:0] spi_rx;
    logic       csn;

    modport master (
        output spi_req,
        output spi_tx,
        output csn,
        input  spi_ack,
        input  spi_rx
    );

    modport slave (
        input  spi_req,
        input  spi_tx,
        input  csn,
        output spi_ack,
        output spi_rx
    );
endinterface

// File: rtl/acl_sched.sv
// rtl/acl_sched.sv - accelerometer boot/config/poll scheduler over a byte-level SPI engine
// Produces sign-magnitude 5-bit x/y/z samples from periodic burst reads.
module acl_sched #(
    parameter int STARTUP_CYCLES = 40000,
    parameter int POLL_CYCLES    = 80000,
    parameter int SHIFT          = 2
) (
    input  logic               clk_8mhz,
    input  logic               nrst,
    acl_sched_if.master        spi,
    output logic [4:0]         x,
    output logic [4:0]         y,
    output logic [4:0]         z,
    output logic               sample_valid,
    output logic               cfg_done
);

    typedef enum logic [2:0] {BOOT, CFG, GAP, IDLE, RD} state_t;
    typedef enum logic {PH_REQ, PH_ACK} phase_t;

    localparam logic [31:0] BOOT_MAX = 32'(STARTUP_CYCLES);
    localparam logic [31:0] POLL_MAX = 32'(POLL_CYCLES);

    state_t      state_q;
    phase_t      ph_q;
    logic [31:0] boot_cnt_q;
    logic [31:0] poll_cnt_q;
    logic [2:0]  byte_q;
    logic        gap_q;
    logic        rd_seen_q;
    logic        spi_req_q;
    logic [7:0]  spi_tx_q;
    logic        csn_q;
    logic [7:0]  raw_x_q;
    logic [7:0]  raw_y_q;
    logic [4:0]  x_q, y_q, z_q;
    logic        sample_valid_q;
    logic        cfg_done_q;

    logic [7:0]  tx_byte_d;
    logic        last_byte_d;
    logic        poll_expired_d;
    logic [4:0]  x_d, y_d, z_d;

    // |raw| of -128 is 128, which fits an unsigned byte, so saturation still applies.
    function automatic logic [4:0] to_sm(input logic [7:0] raw);
        logic [7:0] mag_full;
        logic [7:0] shifted;
        logic [3:0] mag;
        mag_full = raw[7] ? (~raw + 8'd1) : raw;
        shifted  = mag_full >> SHIFT;
        mag      = (shifted > 8'd15) ? 4'd15 : shifted[3:0];
        return {raw[7] && (mag != 4'd0), mag};
    endfunction

    always_comb begin
        tx_byte_d = 8'h00;
        if (state_q == CFG) begin
            case (byte_q)
                3'd0:    tx_byte_d = 8'h0A;
                3'd1:    tx_byte_d = 8'h2D;
                default: tx_byte_d = 8'h02;
            endcase
        end else begin
            case (byte_q)
                3'd0:    tx_byte_d = 8'h0B;
                3'd1:    tx_byte_d = 8'h08;
                default: tx_byte_d = 8'h00;
            endcase
        end
        last_byte_d    = (state_q == CFG) ? (byte_q == 3'd2) : (byte_q == 3'd4);
        poll_expired_d = (poll_cnt_q >= POLL_MAX);
        x_d            = to_sm(raw_x_q);
        y_d            = to_sm(raw_y_q);
        z_d            = to_sm(spi.spi_rx);
    end

    always_ff @(posedge clk_8mhz or negedge nrst) begin
        if (!nrst) begin
            state_q        <= BOOT;
            ph_q           <= PH_REQ;
            boot_cnt_q     <= 32'd0;
            poll_cnt_q     <= 32'd0;
            byte_q         <= 3'd0;
            gap_q          <= 1'b0;
            rd_seen_q      <= 1'b0;
            spi_req_q      <= 1'b0;
            spi_tx_q       <= 8'h00;
            csn_q          <= 1'b1;
            raw_x_q        <= 8'h00;
            raw_y_q        <= 8'h00;
            x_q            <= 5'd0;
            y_q            <= 5'd0;
            z_q            <= 5'd0;
            sample_valid_q <= 1'b0;
            cfg_done_q     <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            // Poll timer saturates, so an expiry during a long read yields exactly one follow-up read.
            if (state_q != BOOT && poll_cnt_q < POLL_MAX) begin
                poll_cnt_q <= poll_cnt_q + 32'd1;
            end
            case (state_q)
                BOOT: begin
                    if (boot_cnt_q == BOOT_MAX) begin
                        state_q <= CFG;
                        csn_q   <= 1'b0;
                        byte_q  <= 3'd0;
                        ph_q    <= PH_REQ;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 32'd1;
                    end
                end
                CFG, RD: begin
                    case (ph_q)
                        PH_REQ: begin
                            spi_req_q <= 1'b1;
                            spi_tx_q  <= tx_byte_d;
                            ph_q      <= PH_ACK;
                        end
                        PH_ACK: begin
                            if (spi.spi_ack) begin
                                spi_req_q <= 1'b0;
                                ph_q      <= PH_REQ;
                                if (state_q == RD && byte_q == 3'd2) raw_x_q <= spi.spi_rx;
                                if (state_q == RD && byte_q == 3'd3) raw_y_q <= spi.spi_rx;
                                if (last_byte_d) begin
                                    csn_q   <= 1'b1;
                                    state_q <= GAP;
                                    gap_q   <= 1'b0;
                                    byte_q  <= 3'd0;
                                    if (state_q == CFG) begin
                                        cfg_done_q <= 1'b1;
                                    end else begin
                                        x_q            <= x_d;
                                        y_q            <= y_d;
                                        z_q            <= z_d;
                                        sample_valid_q <= 1'b1;
                                    end
                                end else begin
                                    byte_q <= byte_q + 3'd1;
                                end
                            end
                        end
                        default: ph_q <= PH_REQ;
                    endcase
                end
                GAP: begin
                    if (!gap_q) begin
                        gap_q <= 1'b1;
                    end else begin
                        gap_q <= 1'b0;
                        if (poll_expired_d || !rd_seen_q) begin
                            state_q    <= RD;
                            csn_q      <= 1'b0;
                            ph_q       <= PH_REQ;
                            byte_q     <= 3'd0;
                            poll_cnt_q <= 32'd1;
                            rd_seen_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (poll_expired_d) begin
                        state_q    <= RD;
                        csn_q      <= 1'b0;
                        ph_q       <= PH_REQ;
                        byte_q     <= 3'd0;
                        poll_cnt_q <= 32'd1;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign spi.spi_req  = spi_req_q;
    assign spi.spi_tx   = spi_tx_q;
    assign spi.csn      = csn_q;
    assign x            = x_q;
    assign y            = y_q;
    assign z            = z_q;
    assign sample_valid = sample_valid_q;
    assign cfg_done     = cfg_done_q;

endmodule
